// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port byte-write RAM.
// RAM_ARB_RR_EN selects round-robin ties; default is fixed m1 priority.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_wstrb,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_wstrb,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              any_req;
  logic              gnt_m1;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  assign any_req = m0_req | m1_req;

`ifdef RAM_ARB_RR_EN
  logic last_grant_q;

  // On a tie, the master not served last time wins.
  always_comb begin
    gnt_m1 = m1_req & (~m0_req | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_grant_q <= gnt_m1;
    end
  end
`else
  always_comb begin
    gnt_m1 = m1_req;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = addr_q;
    ram_din  = wdata_q;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    unique case (state_q)
      ACCESS: begin
        ram_en = 1'b1;
        ram_we = wstrb_q;
      end
      RESP: begin
        m0_ack = ~owner_q;
        m1_ack = owner_q;
      end
      default: ;
    endcase
  end

  // Request latch in IDLE; read capture into owner's register in ACCESS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= gnt_m1;
        addr_q  <= gnt_m1 ? m1_addr  : m0_addr;
        wstrb_q <= gnt_m1 ? m1_wstrb : m0_wstrb;
        wdata_q <= gnt_m1 ? m1_wdata : m0_wdata;
      end
      if (state_q == ACCESS) begin
        if (owner_q) m1_rdata_q <= ram_dout;
        else         m0_rdata_q <= ram_dout;
      end
    end
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter against a
// transaction-level memory and arbitration model.
module tb_ram_arbiter;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [3:0]  m0_wstrb = '0;
  logic [31:0] m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [3:0]  m1_wstrb = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic [15:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  bit [31:0] mem    [0:65535];
  bit [31:0] shadow [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0;
  logic [31:0] pre_d = '0;

  int checks = 0;
  int failures = 0;
  bit        last_g = 1'b1;
  logic [31:0] exp_rd [2];
  bit glog [$];

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b+:8] <= ram_din[8*b+:8];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic set_m(input bit m, input bit r, input logic [15:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (m) begin
      m1_req = r; m1_addr = a; m1_wstrb = s; m1_wdata = d;
    end else begin
      m0_req = r; m0_addr = a; m0_wstrb = s; m0_wdata = d;
    end
  endtask

  // One full transaction from IDLE back to IDLE, checked against the model.
  task automatic run(input bit keep);
    bit          w;
    logic [15:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    if (m0_req && m1_req) w = RR ? ~last_g : 1'b1;
    else                  w = m1_req;
    a = w ? m1_addr  : m0_addr;
    s = w ? m1_wstrb : m0_wstrb;
    d = w ? m1_wdata : m0_wdata;
    chk("idle_en", ram_en, 0);
    chk("idle_we", ram_we, 0);
    tick();
    chk("acc_en", ram_en, 1);
    chk("acc_we", ram_we, s);
    chk("acc_addr", ram_addr, a);
    chk("acc_din", ram_din, d);
    chk("acc_acks", {m0_ack, m1_ack}, 0);
    tick();
    exp_rd[w] = shadow[a];
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[a][8*b+:8] = d[8*b+:8];
    last_g = w;
    glog.push_back(w);
    chk("resp_en", ram_en, 0);
    chk("resp_ack0", m0_ack, !w);
    chk("resp_ack1", m1_ack, w);
    chk("resp_rd0", m0_rdata, exp_rd[0]);
    chk("resp_rd1", m1_rdata, exp_rd[1]);
    if (!keep) begin
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    tick();
    chk("post_acks", {m0_ack, m1_ack}, 0);
  endtask

  initial begin
    bit gexp [4];
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    #1;
    chk("rst_ack", {m0_ack, m1_ack}, 0);
    chk("rst_rd0", m0_rdata, 0);
    chk("rst_rd1", m1_rdata, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);

    pre_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pre_a = 16'(i);
      pre_d = $urandom;
      shadow[i] = pre_d;
      tick();
    end
    pre_a = 16'h0020;
    pre_d = 32'h1122_3344;
    shadow[16'h0020] = pre_d;
    tick();
    pre_we = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();

    set_m(1, 1, 16'h0010, 4'hF, 32'hDEAD_BEEF);
    run(0);
    set_m(1, 1, 16'h0010, 4'h0, 32'h0);
    run(0);
    chk("t1_rd", m1_rdata, 32'hDEAD_BEEF);

    set_m(1, 1, 16'h0020, 4'b0010, 32'h0000_AA00);
    run(0);
    chk("t2_old", m1_rdata, 32'h1122_3344);
    set_m(1, 1, 16'h0020, 4'h0, 32'h0);
    run(0);
    chk("t2_rd", m1_rdata, 32'h1122_AA44);

    set_m(0, 1, 16'h0004, 4'h0, 32'h0);
    run(0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(1, 3);
      set_m(0, r[0], 16'($urandom_range(0, 63)), 4'($urandom),
            $urandom);
      set_m(1, r[1], 16'($urandom_range(0, 63)), 4'($urandom),
            $urandom);
      run(0);
    end

    set_m(1, 1, 16'h0030, 4'hF, 32'hCAFE_F00D);
    chk("t5_idle_en", ram_en, 0);
    tick();
    chk("t5_acc_we", ram_we, 4'hF);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_we", ram_we, 0);
    chk("t5_rst_en", ram_en, 0);
    m1_req = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_g = 1'b1;
    tick();
    chk("t5_rst_ack", {m0_ack, m1_ack}, 0);
    chk("t5_mem", mem[16'h0030], shadow[16'h0030]);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("t5_rd1", m1_rdata, 0);
    set_m(0, 1, 16'h0030, 4'h0, 32'h0);
    run(0);

    resetn = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    last_g = 1'b1;
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    glog.delete();
    set_m(0, 1, 16'h0008, 4'h0, 32'h0);
    set_m(1, 1, 16'h000C, 4'h0, 32'h0);
    run(1);
    run(1);
    run(1);
    run(0);
    if (RR) gexp = '{1'b0, 1'b1, 1'b0, 1'b1};
    else    gexp = '{1'b1, 1'b1, 1'b1, 1'b1};
    chk("t3_len", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("t3_grant", glog[i], gexp[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
